// File: rtl/qspi_mem_ctrl.sv
// Quad-SPI PSRAM controller: single-word reads/writes over a 4-bit bus.
// On reset release it sends 0x35 (enter quad mode) on io0 before serving the host.
`timescale 1ns/1ps
module qspi_mem_ctrl #(
   parameter int DUMMY_CYCLES = 4
) (
   input  logic        clk_i,
   input  logic        rst_in,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [23:0] adr_i,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   output logic        ack_o,
   output logic        sck_o,
   output logic        cs_on,
   output logic [3:0]  io_o,
   output logic [3:0]  io_oe_o,
   input  logic [3:0]  io_i
);

   typedef enum logic [3:0] {
      INIT, INIT_GAP, IDLE, CMD, ADR, DUMMY, RDATA, WDATA, GAP
   } state_t;

   localparam logic [7:0] INIT_BYTE  = 8'h35;
   localparam logic [7:0] CMD_WRITE  = 8'h38;
   localparam logic [7:0] CMD_READ   = 8'h0B;
   localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

   state_t      state, state_d;
   logic [7:0]  cnt, cnt_d;
   logic        run;
   logic        done_d;
   logic        cs_d;
   logic [3:0]  io_d, oe_d;
   logic [7:0]  cmd_byte;
   logic [31:0] rd_sr;

   // Address goes out most significant nibble first.
   function automatic logic [3:0] adr_nibble(input logic [23:0] a, input logic [2:0] idx);
      logic [4:0] lsb;
      lsb = {3'(3'd5 - idx), 2'b00};
      return a[lsb +: 4];
   endfunction

   // Data bytes go out least significant byte first, high nibble of each byte first.
   function automatic logic [3:0] wr_nibble(input logic [31:0] d, input logic [2:0] idx);
      logic [4:0] lsb;
      lsb = {idx[2:1], ~idx[0], 2'b00};
      return d[lsb +: 4];
   endfunction

   function automatic logic [31:0] byte_swap(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   assign cmd_byte = we_i ? CMD_WRITE : CMD_READ;

   // state/cnt describe the sck period currently on the bus; they advance on sck falling edges
   always_comb begin
      state_d = state;
      cnt_d   = cnt + 8'd1;
      done_d  = 1'b0;
      if (!run) begin
         state_d = INIT;
         cnt_d   = '0;
      end else begin
         case (state)
            INIT: begin
               if (cnt == 8'd7) begin
                  state_d = INIT_GAP;
                  cnt_d   = '0;
               end
            end
            INIT_GAP, GAP: begin
               if (cnt == 8'd1) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            IDLE: begin
               cnt_d = '0;
               if (stb_i) state_d = CMD;
            end
            CMD: begin
               if (cnt == 8'd1) begin
                  state_d = ADR;
                  cnt_d   = '0;
               end
            end
            ADR: begin
               if (cnt == 8'd5) begin
                  cnt_d = '0;
                  if (we_i) state_d = WDATA;
                  else if (DUMMY_CYCLES == 0) state_d = RDATA;
                  else state_d = DUMMY;
               end
            end
            DUMMY: begin
               if (cnt == DUMMY_LAST) begin
                  state_d = RDATA;
                  cnt_d   = '0;
               end
            end
            RDATA, WDATA: begin
               if (cnt == 8'd7) begin
                  state_d = GAP;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end
            end
            default: begin
               state_d = INIT;
               cnt_d   = '0;
            end
         endcase
      end

      cs_d = 1'b1;
      io_d = 4'b0000;
      oe_d = 4'b0000;
      case (state_d)
         INIT: begin
            cs_d = 1'b0;
            oe_d = 4'b0001;
            io_d = {3'b000, INIT_BYTE[3'd7 - cnt_d[2:0]]};
         end
         CMD: begin
            cs_d = 1'b0;
            oe_d = 4'b1111;
            io_d = cnt_d[0] ? cmd_byte[3:0] : cmd_byte[7:4];
         end
         ADR: begin
            cs_d = 1'b0;
            oe_d = 4'b1111;
            io_d = adr_nibble(adr_i, cnt_d[2:0]);
         end
         WDATA: begin
            cs_d = 1'b0;
            oe_d = 4'b1111;
            io_d = wr_nibble(dat_i, cnt_d[2:0]);
         end
         DUMMY, RDATA: cs_d = 1'b0;
         default: ;
      endcase
   end

   // Bus outputs launch on sck falling edges so the device sees them stable at its rising edge.
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         sck_o   <= 1'b0;
         state   <= INIT;
         cnt     <= '0;
         run     <= 1'b0;
         cs_on   <= 1'b1;
         io_o    <= 4'b0000;
         io_oe_o <= 4'b0000;
         ack_o   <= 1'b0;
         dat_o   <= '0;
      end else begin
         sck_o <= ~sck_o;
         ack_o <= sck_o & done_d;
         if (sck_o) begin
            state   <= state_d;
            cnt     <= cnt_d;
            run     <= 1'b1;
            cs_on   <= cs_d;
            io_o    <= io_d;
            io_oe_o <= oe_d;
            if (done_d && state == RDATA) dat_o <= byte_swap(rd_sr);
         end
      end
   end

   // Read nibbles are captured on sck rising edges, first-arriving nibble ends up in the top bits.
   always_ff @(posedge clk_i) begin
      if (!sck_o && state == RDATA) rd_sr <= {rd_sr[27:0], io_i};
   end

endmodule

// File: tb/tb_qspi_mem_ctrl.sv
// Bench for qspi_mem_ctrl: QSPI PSRAM device model, reference memory and ack scoreboard.
`timescale 1ns/1ps
module tb_qspi_mem_ctrl;
   localparam int DUMMY = 4;
   localparam int CLK_P = 10;
   localparam int NRAND = 20;

   logic        clk_i = 1'b0;
   logic        rst_in;
   logic        stb_i, we_i;
   logic [23:0] adr_i;
   logic [31:0] dat_i, dat_o;
   logic        ack_o, sck_o, cs_on;
   logic [3:0]  io_o, io_oe_o, io_i;

   qspi_mem_ctrl #(.DUMMY_CYCLES(DUMMY)) dut (
      .clk_i(clk_i), .rst_in(rst_in), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
      .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .sck_o(sck_o), .cs_on(cs_on),
      .io_o(io_o), .io_oe_o(io_oe_o), .io_i(io_i)
   );

   always #(CLK_P/2) clk_i = ~clk_i;

   typedef struct {
      logic        we;
      logic [23:0] adr;
      logic [31:0] dat;
   } bus_exp_t;

   bus_exp_t    bus_q[$];
   logic [31:0] ack_q[$];
   logic [7:0]  ref_mem [int];
   logic [7:0]  dev_mem [int];
   logic [31:0] ref_last_rd = '0;
   int n_cmp = 0, n_bad = 0, n_exp_ack = 0, ack_cnt = 0, init_frames = 0, stable_viol = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_read(input logic [23:0] a);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) begin
         int k;
         k = int'(a + 24'(i));
         w[8*i +: 8] = ref_mem.exists(k) ? ref_mem[k] : 8'h00;
      end
      return w;
   endfunction

   task automatic xfer(input logic w, input logic [23:0] a, input logic [31:0] d, input logic hold);
      bus_exp_t be;
      int t;
      be.we = w; be.adr = a; be.dat = d;
      bus_q.push_back(be);
      if (w) begin
         for (int i = 0; i < 4; i++) ref_mem[int'(a + 24'(i))] = d[8*i +: 8];
      end else begin
         ref_last_rd = ref_read(a);
      end
      ack_q.push_back(ref_last_rd);
      n_exp_ack++;
      stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
      t = 0;
      do begin
         @(negedge clk_i);
         t++;
      end while (ack_o !== 1'b1 && t < 1000);
      check("ack_seen", 64'(ack_o === 1'b1), 64'd1);
      if (!hold) stb_i = 1'b0;
   endtask

   // PSRAM device model: records each cs-low frame, serves reads, stores writes
   initial begin : psram
      logic [3:0]  f_io[$];
      logic [3:0]  f_oe[$];
      logic        rd_mode;
      logic [23:0] rd_adr, fa;
      time         last_end;
      bit          have_end;
      bus_exp_t    be;
      int          j, bad;
      logic [7:0]  b;
      logic [31:0] w;
      io_i = 4'h0; have_end = 0; last_end = 0;
      forever begin
         @(negedge cs_on);
         #1;
         if (rst_in !== 1'b1) continue;
         if (have_end) check("cs_gap", 64'(($time - last_end) >= 4 * CLK_P), 64'd1);
         f_io.delete(); f_oe.delete(); rd_mode = 1'b0; rd_adr = '0;
         forever begin
            @(posedge sck_o or posedge cs_on);
            #1;
            if (cs_on !== 1'b0) break;
            f_io.push_back(io_o);
            f_oe.push_back(io_oe_o);
            io_i = 4'($urandom);
            if (f_io.size() == 8) begin
               rd_mode = ({f_io[0], f_io[1]} == 8'h0B) && (f_oe[0] == 4'hF);
               rd_adr  = {f_io[2], f_io[3], f_io[4], f_io[5], f_io[6], f_io[7]};
            end
            @(negedge sck_o or posedge cs_on);
            #1;
            if (cs_on !== 1'b0) break;
            j = f_io.size() - 8 - DUMMY;
            if (rd_mode && j >= 0 && j < 8) begin
               b = dev_mem.exists(int'(rd_adr + 24'(j / 2))) ? dev_mem[int'(rd_adr + 24'(j / 2))] : 8'h00;
               io_i = (j % 2 == 0) ? b[7:4] : b[3:0];
            end
         end
         last_end = $time; have_end = 1;
         if (rst_in !== 1'b1) begin
            if (bus_q.size() > 0) be = bus_q.pop_front();
         end else if (f_oe.size() > 0 && f_oe[0] == 4'b0001) begin
            init_frames++;
            check("init_len", 64'(f_io.size()), 64'd8);
            bad = 0; b = '0;
            foreach (f_io[i]) begin
               if (f_oe[i] != 4'b0001) bad++;
               if (i < 8) b[7 - i] = f_io[i][0];
            end
            check("init_oe", 64'(bad), 64'd0);
            check("init_byte", 64'(b), 64'h35);
         end else begin
            check("frame_expected", 64'(bus_q.size() > 0), 64'd1);
            check("frame_len_ge8", 64'(f_io.size() >= 8), 64'd1);
            if (bus_q.size() > 0 && f_io.size() >= 8) begin
               be = bus_q.pop_front();
               fa = {f_io[2], f_io[3], f_io[4], f_io[5], f_io[6], f_io[7]};
               check("frame_cmd", 64'({f_io[0], f_io[1]}), be.we ? 64'h38 : 64'h0B);
               check("frame_adr", 64'(fa), 64'(be.adr));
               bad = 0;
               for (int i = 0; i < 8; i++) if (f_oe[i] != 4'hF) bad++;
               check("frame_hdr_oe", 64'(bad), 64'd0);
               if (be.we) begin
                  check("wr_len", 64'(f_io.size()), 64'd16);
                  if (f_io.size() >= 16) begin
                     bad = 0;
                     for (int i = 8; i < 16; i++) if (f_oe[i] != 4'hF) bad++;
                     check("wr_data_oe", 64'(bad), 64'd0);
                     w = {f_io[14], f_io[15], f_io[12], f_io[13], f_io[10], f_io[11], f_io[8], f_io[9]};
                     check("wr_data", 64'(w), 64'(be.dat));
                     for (int i = 0; i < 4; i++) dev_mem[int'(fa + 24'(i))] = {f_io[8 + 2*i], f_io[9 + 2*i]};
                  end
               end else begin
                  bad = 0;
                  for (int i = 8; i < f_io.size(); i++) if (f_oe[i] != 4'h0) bad++;
                  check("rd_tail_oe", 64'(bad), 64'd0);
               end
            end
         end
      end
   end

   // Scoreboard side: each ack pops one expected dat_o
   initial begin : ack_mon
      logic        ack_prev;
      logic [31:0] e;
      ack_prev = 1'b0;
      forever begin
         @(negedge clk_i);
         if (ack_o === 1'b1) begin
            ack_cnt++;
            check("ack_single", 64'(ack_prev), 64'd0);
            check("ack_cs_high", 64'(cs_on), 64'd1);
            check("ack_expected", 64'(ack_q.size() > 0), 64'd1);
            if (ack_q.size() > 0) begin
               e = ack_q.pop_front();
               check("dat_o", 64'(dat_o), 64'(e));
            end
         end
         ack_prev = ack_o;
      end
   end

   // Bus outputs must not move on the clk edge where sck rises
   initial begin : stab
      logic [8:0] prev;
      bit have_prev;
      have_prev = 0; prev = '0;
      forever begin
         @(posedge clk_i);
         #1;
         if (have_prev && rst_in === 1'b1 && sck_o === 1'b1 && {cs_on, io_o, io_oe_o} !== prev)
            stable_viol++;
         prev = {cs_on, io_o, io_oe_o};
         have_prev = 1;
      end
   end

   initial begin : watchdog
      #(CLK_P * 50000);
      $display("FAIL watchdog: got no completion, want $finish within budget");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [23:0] a;
      logic        w, h;
      int          t;
      bus_exp_t    be;
      rst_in = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0;
      #(CLK_P + 2);
      check("rst_cs", 64'(cs_on), 64'd1);
      check("rst_sck", 64'(sck_o), 64'd0);
      check("rst_oe", 64'(io_oe_o), 64'd0);
      check("rst_io", 64'(io_o), 64'd0);
      check("rst_ack", 64'(ack_o), 64'd0);
      check("rst_dat", 64'(dat_o), 64'd0);
      repeat (3) @(negedge clk_i);
      rst_in = 1'b1;

      xfer(1'b1, 24'h000010, 32'h89ABCDEF, 1'b0);
      xfer(1'b0, 24'h000010, 32'h0, 1'b0);
      xfer(1'b1, 24'h000020, 32'h13579BDF, 1'b1);
      xfer(1'b0, 24'h000020, 32'h0, 1'b0);

      for (int i = 0; i < NRAND; i++) begin
         case ($urandom_range(0, 4))
            0:       a = 24'h000014;
            1:       a = 24'h000020;
            2:       a = 24'hFFFFFE;
            3:       a = 24'h123457;
            default: a = {1'b1, 23'($urandom)};
         endcase
         w = 1'($urandom_range(0, 1));
         h = (i != NRAND - 1) && ($urandom_range(0, 1) == 1);
         xfer(w, a, $urandom, h);
      end

      // Abort a read mid-data with reset
      be.we = 1'b0; be.adr = 24'h000010; be.dat = '0;
      bus_q.push_back(be);
      stb_i = 1'b1; we_i = 1'b0; adr_i = 24'h000010;
      t = 0;
      while (cs_on !== 1'b0 && t < 1000) begin
         @(negedge clk_i);
         t++;
      end
      check("abort_cs_low", 64'(cs_on), 64'd0);
      repeat (2 * (8 + DUMMY + 3)) @(negedge clk_i);
      #2 rst_in = 1'b0;
      #1;
      check("abort_cs", 64'(cs_on), 64'd1);
      check("abort_oe", 64'(io_oe_o), 64'd0);
      check("abort_ack", 64'(ack_o), 64'd0);
      check("abort_sck", 64'(sck_o), 64'd0);
      check("abort_dat", 64'(dat_o), 64'd0);
      stb_i = 1'b0;
      ref_last_rd = '0;
      repeat (4) @(negedge clk_i);
      rst_in = 1'b1;

      xfer(1'b0, 24'h000010, 32'h0, 1'b0);
      repeat (20) @(negedge clk_i);

      check("ack_count", 64'(ack_cnt), 64'(n_exp_ack));
      check("init_frames", 64'(init_frames), 64'd2);
      check("bus_q_empty", 64'(bus_q.size()), 64'd0);
      check("ack_q_empty", 64'(ack_q.size()), 64'd0);
      check("out_stable", 64'(stable_viol), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
